// File: rtl/self_trigger_pkg.sv
// Shared types for the ADC self-trigger controller.
package self_trigger_pkg;

    // Acquisition sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        WAIT_RECORD,
        PRE_FILL,
        WAIT_TRIGGER,
        POST_CAPTURE,
        LOCK
    } state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chIdxW(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

endpackage

// File: rtl/self_trigger_ctrl_if.sv
// Control/sample bus between the capture host and the self-trigger controller.
interface self_trigger_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 12,
    parameter int TO_W   = 24
);
    import self_trigger_pkg::*;

    localparam int CH_W = chIdxW(NUM_CH);

    logic                     self_trigger_mode;
    logic                     record_cmd;
    logic                     auto_rearm;
    logic [NUM_CH-1:0]        ch_enable;
    logic [NUM_CH*DATA_W-1:0] ch_sample;
    logic                     sample_valid;
    logic [DATA_W-1:0]        threshold;
    logic                     rising_edge;
    logic [CNT_W-1:0]         pre_count;
    logic [CNT_W-1:0]         post_count;
    logic [TO_W-1:0]          timeout;
    logic                     read_done;

    logic                     wait_for_trigger;
    logic                     capturing;
    logic                     hold_trigger;
    logic                     trigger_pulse;
    logic [CH_W-1:0]          trig_channel;
    logic                     trig_forced;

    modport master (
        output self_trigger_mode, record_cmd, auto_rearm, ch_enable, ch_sample,
               sample_valid, threshold, rising_edge, pre_count, post_count,
               timeout, read_done,
        input  wait_for_trigger, capturing, hold_trigger, trigger_pulse,
               trig_channel, trig_forced
    );

    modport slave (
        input  self_trigger_mode, record_cmd, auto_rearm, ch_enable, ch_sample,
               sample_valid, threshold, rising_edge, pre_count, post_count,
               timeout, read_done,
        output wait_for_trigger, capturing, hold_trigger, trigger_pulse,
               trig_channel, trig_forced
    );

endinterface

// File: rtl/trigger_crossing_detect.sv
// Per-channel threshold crossing detector: remembers the previous valid
// sample and flags a crossing of the requested polarity on the current one.
module trigger_crossing_detect #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sampleValid,
    input  logic              enable,
    input  logic              risingEdge,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] threshold,
    output logic              hit
);

    logic [DATA_W-1:0] prevSample;
    logic              prevValid;
    logic              prevAbove;
    logic              curAbove;

    // Track the last valid sample; clear wins so the first sample after
    // arming only primes the history and can never fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevSample <= '0;
            prevValid  <= 1'b0;
        end else if (clear) begin
            prevValid  <= 1'b0;
        end else if (sampleValid) begin
            prevSample <= sample;
            prevValid  <= 1'b1;
        end
    end

    // Unsigned level compare against the shared threshold.
    always_comb begin
        prevAbove = (prevSample >= threshold);
        curAbove  = (sample >= threshold);
        hit       = enable && sampleValid && prevValid &&
                    (risingEdge ? (!prevAbove && curAbove) : (prevAbove && !curAbove));
    end

endmodule

// File: rtl/self_trigger_ctrl.sv
// Multi-channel self-trigger controller: sequences arm, pre-fill, trigger
// wait, post-capture and read lock, with forced-trigger timeout and rearm.
module self_trigger_ctrl
    import self_trigger_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 12,
    parameter int TO_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    self_trigger_ctrl_if.slave bus
);

    localparam int CH_W = chIdxW(NUM_CH);

    state_t            state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  preQ, postQ;
    logic [TO_W-1:0]   toCnt, timeoutQ;
    logic [DATA_W-1:0] thrQ;
    logic              risingQ;

    logic [NUM_CH-1:0] hit;
    logic [CH_W-1:0]   hitCh;
    logic              anyHit, forceHit, fire, detClear, startAcq;

    logic              trigPulseQ, trigForcedQ;
    logic [CH_W-1:0]   trigChQ;

    trigger_crossing_detect #(.DATA_W(DATA_W)) uDet [NUM_CH-1:0] (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (detClear),
        .sampleValid(bus.sample_valid),
        .enable     (bus.ch_enable),
        .risingEdge (risingQ),
        .sample     (bus.ch_sample),
        .threshold  (thrQ),
        .hit        (hit)
    );

    // Lowest channel index wins when several cross together.
    always_comb begin
        hitCh = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) hitCh = CH_W'(i);
        end
    end

    assign anyHit   = |hit;
    assign forceHit = (timeoutQ != '0) && (toCnt == timeoutQ);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic; dropping mode aborts everything except LOCK.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.self_trigger_mode) nextState = WAIT_RECORD;
            end
            WAIT_RECORD: begin
                if (!bus.self_trigger_mode) nextState = IDLE;
                else if (bus.record_cmd)
                    nextState = (bus.pre_count == '0) ? WAIT_TRIGGER : PRE_FILL;
            end
            PRE_FILL: begin
                if (!bus.self_trigger_mode) nextState = IDLE;
                else if (bus.sample_valid && (cnt + CNT_W'(1)) == preQ)
                    nextState = WAIT_TRIGGER;
            end
            WAIT_TRIGGER: begin
                if (!bus.self_trigger_mode) nextState = IDLE;
                else if (anyHit || forceHit) nextState = POST_CAPTURE;
            end
            POST_CAPTURE: begin
                if (!bus.self_trigger_mode) nextState = IDLE;
                else if (postQ == '0 ||
                         (bus.sample_valid && (cnt + CNT_W'(1)) == postQ))
                    nextState = LOCK;
            end
            LOCK: begin
                if (bus.read_done) begin
                    if (!bus.self_trigger_mode) nextState = IDLE;
                    else if (bus.auto_rearm)
                        nextState = (bus.pre_count == '0) ? WAIT_TRIGGER : PRE_FILL;
                    else nextState = WAIT_RECORD;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign fire     = (state == WAIT_TRIGGER) && (nextState == POST_CAPTURE);
    assign detClear = (state != WAIT_TRIGGER) && (nextState == WAIT_TRIGGER);
    assign startAcq = ((state == WAIT_RECORD) || (state == LOCK)) &&
                      ((nextState == PRE_FILL) || (nextState == WAIT_TRIGGER));

    // Sample counter for pre-fill / post-capture; cleared on any state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (nextState != state)
            cnt <= '0;
        else if ((state == PRE_FILL || state == POST_CAPTURE) &&
                 bus.sample_valid && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

    // Timeout counter: reads k on the k-th cycle after entering WAIT_TRIGGER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            toCnt <= '0;
        else if (state == WAIT_TRIGGER && nextState == WAIT_TRIGGER)
            toCnt <= toCnt + TO_W'(1);
        else
            toCnt <= '0;
    end

    // Freeze acquisition settings when an acquisition starts, so host-side
    // changes only take effect on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preQ     <= '0;
            postQ    <= '0;
            timeoutQ <= '0;
            thrQ     <= '0;
            risingQ  <= 1'b0;
        end else if (startAcq) begin
            preQ     <= bus.pre_count;
            postQ    <= bus.post_count;
            timeoutQ <= bus.timeout;
            thrQ     <= bus.threshold;
            risingQ  <= bus.rising_edge;
        end
    end

    // Trigger report: pulse for one cycle, channel/forced hold until the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigPulseQ  <= 1'b0;
            trigChQ     <= '0;
            trigForcedQ <= 1'b0;
        end else begin
            trigPulseQ <= fire;
            if (fire) begin
                trigChQ     <= anyHit ? hitCh : '0;
                trigForcedQ <= !anyHit;
            end
        end
    end

    assign bus.wait_for_trigger = (state == WAIT_TRIGGER);
    assign bus.capturing        = (state == PRE_FILL) || (state == WAIT_TRIGGER) ||
                                  (state == POST_CAPTURE);
    assign bus.hold_trigger     = (state == LOCK);
    assign bus.trigger_pulse    = trigPulseQ;
    assign bus.trig_channel     = trigChQ;
    assign bus.trig_forced      = trigForcedQ;

endmodule

// File: tb/tb_self_trigger_ctrl.sv
// Directed bench for self_trigger_ctrl: expected trigger events are queued
// by the stimulus and checked by an independent monitor.
module tb_self_trigger_ctrl;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 12;
    localparam int TO_W   = 24;

    typedef struct {
        int ch;
        int forced;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   nTests = 0;
    int   nFail  = 0;
    exp_t expQ[$];

    self_trigger_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .TO_W(TO_W)) bus();

    self_trigger_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [2:0] st;
    logic [2:0] tr;
    assign st = {bus.wait_for_trigger, bus.capturing, bus.hold_trigger};
    assign tr = {bus.trig_forced, bus.trig_channel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Status encodings {wait_for_trigger, capturing, hold_trigger}
    localparam logic [2:0] S_OFF  = 3'b000;
    localparam logic [2:0] S_PRE  = 3'b010;
    localparam logic [2:0] S_WAIT = 3'b110;
    localparam logic [2:0] S_POST = 3'b010;
    localparam logic [2:0] S_LOCK = 3'b001;

    task automatic chk(input string nm, input int got, input int exp);
        nTests++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic setS(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
        bus.ch_sample = {s3, s2, s1, s0};
    endtask

    task automatic step(input logic v);
        bus.sample_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic stepS(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        setS(s0, s1, s2, s3);
        step(1'b1);
    endtask

    task automatic pulseRec();
        bus.record_cmd = 1'b1;
        step(1'b0);
        bus.record_cmd = 1'b0;
    endtask

    task automatic pulseRd();
        bus.read_done = 1'b1;
        step(1'b0);
        bus.read_done = 1'b0;
    endtask

    task automatic expTrig(input int ch, input int forced, input int at);
        exp_t e;
        e.ch = ch; e.forced = forced; e.cyc = at;
        expQ.push_back(e);
    endtask

    // Monitor: every trigger pulse must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.trigger_pulse === 1'b1) begin
                nTests++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL trig_unexpected ch=%0d forced=%0d cyc=%0d",
                             bus.trig_channel, bus.trig_forced, cyc);
                end else begin
                    e = expQ.pop_front();
                    if (int'(bus.trig_channel) != e.ch || int'(bus.trig_forced) != e.forced ||
                        cyc != e.cyc) begin
                        nFail++;
                        $display("FAIL trig_event got ch=%0d forced=%0d cyc=%0d expected ch=%0d forced=%0d cyc=%0d",
                                 bus.trig_channel, bus.trig_forced, cyc, e.ch, e.forced, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.self_trigger_mode = 1'b0;
        bus.record_cmd   = 1'b0;
        bus.auto_rearm   = 1'b0;
        bus.ch_enable    = 4'hF;
        bus.sample_valid = 1'b0;
        bus.threshold    = 8'h80;
        bus.rising_edge  = 1'b1;
        bus.pre_count    = '0;
        bus.post_count   = '0;
        bus.timeout      = '0;
        bus.read_done    = 1'b0;
        setS(8'h10, 8'h10, 8'h10, 8'h10);
        step(1'b0); step(1'b0);
        chk("reset_status", st, S_OFF);
        chk("reset_trig", tr, 0);
        chk("reset_pulse", bus.trigger_pulse, 0);
        rst_n = 1'b1;
        step(1'b0);

        // Basic rising trigger on ch1, pre=3 post=5
        bus.self_trigger_mode = 1'b1;
        step(1'b0);
        chk("t1_wait_record", st, S_OFF);
        bus.pre_count = 3; bus.post_count = 5;
        pulseRec();
        chk("t1_prefill", st, S_PRE);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        step(1'b0);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        chk("t1_prefill_2of3", st, S_PRE);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        chk("t1_wait_trigger", st, S_WAIT);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        step(1'b0);
        chk("t1_no_early_trig", st, S_WAIT);
        stepS(8'h10, 8'h90, 8'h10, 8'h10);
        expTrig(1, 0, cyc);
        chk("t1_post", st, S_POST);
        repeat (2) stepS(8'h10, 8'h90, 8'h10, 8'h10);
        step(1'b0);
        repeat (2) stepS(8'h10, 8'h90, 8'h10, 8'h10);
        chk("t1_post_4of5", st, S_POST);
        stepS(8'h10, 8'h90, 8'h10, 8'h10);
        chk("t1_lock", st, S_LOCK);
        pulseRec();
        step(1'b0);
        chk("t1_lock_hold", st, S_LOCK);
        chk("t1_trig_fields", tr, 3'b001);
        pulseRd();
        chk("t1_back_wait_record", st, S_OFF);

        // Priority and enable: ch0 disabled, ch2+ch3 cross together
        bus.ch_enable = 4'b1110; bus.pre_count = 0; bus.post_count = 0;
        pulseRec();
        chk("t2_direct_wait", st, S_WAIT);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        stepS(8'h90, 8'h10, 8'h10, 8'h10);
        chk("t2_ch0_disabled", st, S_WAIT);
        stepS(8'h90, 8'h10, 8'h90, 8'hA0);
        expTrig(2, 0, cyc);
        chk("t2_post", st, S_POST);
        step(1'b0);
        chk("t2_post0_lock", st, S_LOCK);
        pulseRd();
        chk("t2_wait_record", st, S_OFF);
        bus.ch_enable = 4'hF;

        // Falling edge, first-sample rule, threshold latched
        bus.rising_edge = 1'b0; bus.pre_count = 1; bus.post_count = 1;
        pulseRec();
        chk("t3_prefill", st, S_PRE);
        stepS(8'h90, 8'h90, 8'h90, 8'h90);
        chk("t3_wait", st, S_WAIT);
        bus.threshold = 8'h00;
        stepS(8'h70, 8'h90, 8'h90, 8'h90);
        chk("t3_first_sample_no_trig", st, S_WAIT);
        stepS(8'h90, 8'h90, 8'h90, 8'h90);
        chk("t3_rise_ignored", st, S_WAIT);
        stepS(8'h70, 8'h90, 8'h90, 8'h90);
        expTrig(0, 0, cyc);
        chk("t3_post", st, S_POST);
        stepS(8'h70, 8'h90, 8'h90, 8'h90);
        chk("t3_lock", st, S_LOCK);
        pulseRd();
        bus.threshold = 8'h80; bus.rising_edge = 1'b1;

        // Timeout = 100 with no crossings, timeout latched
        bus.pre_count = 0; bus.post_count = 0; bus.timeout = 100;
        pulseRec();
        chk("t4_wait", st, S_WAIT);
        bus.timeout = 5;
        expTrig(0, 1, cyc + 101);
        repeat (100) stepS(8'h10, 8'h10, 8'h10, 8'h10);
        chk("t4_still_waiting", st, S_WAIT);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        chk("t4_forced_post", st, S_POST);
        step(1'b0);
        chk("t4_lock", st, S_LOCK);
        chk("t4_trig_fields", tr, 3'b100);
        pulseRd();

        // Timeout with a real crossing in the same cycle
        bus.timeout = 100;
        pulseRec();
        expTrig(3, 0, cyc + 101);
        repeat (100) stepS(8'h10, 8'h10, 8'h10, 8'h10);
        stepS(8'h10, 8'h10, 8'h10, 8'h90);
        chk("t4b_post", st, S_POST);
        chk("t4b_trig_fields", tr, 3'b011);
        step(1'b0);
        pulseRd();
        bus.timeout = 0;

        // Auto-rearm with pre=0, then abort in POST_CAPTURE
        bus.auto_rearm = 1'b1;
        pulseRec();
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        stepS(8'h10, 8'h90, 8'h10, 8'h10);
        expTrig(1, 0, cyc);
        step(1'b0);
        chk("t5_lock", st, S_LOCK);
        bus.post_count = 3;
        pulseRd();
        chk("t5_auto_rearm", st, S_WAIT);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        stepS(8'h10, 8'h90, 8'h10, 8'h10);
        expTrig(1, 0, cyc);
        chk("t5_post", st, S_POST);
        bus.self_trigger_mode = 1'b0;
        step(1'b0);
        chk("t5_abort_post", st, S_OFF);
        bus.self_trigger_mode = 1'b1;
        pulseRec();
        chk("t5_idle_ignores_record", st, S_OFF);

        // Dropping mode in LOCK waits for read_done, then IDLE
        bus.auto_rearm = 1'b0; bus.post_count = 0;
        pulseRec();
        chk("t5_wait2", st, S_WAIT);
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        stepS(8'h10, 8'h10, 8'h90, 8'h10);
        expTrig(2, 0, cyc);
        step(1'b0);
        bus.self_trigger_mode = 1'b0;
        step(1'b0);
        chk("t5_lock_no_abort", st, S_LOCK);
        step(1'b0);
        chk("t5_lock_still", st, S_LOCK);
        pulseRd();
        chk("t5_lock_exit", st, S_OFF);
        bus.self_trigger_mode = 1'b1;
        pulseRec();
        chk("t5_lock_exit_idle", st, S_OFF);

        // Async reset mid-POST_CAPTURE
        bus.post_count = 5;
        pulseRec();
        stepS(8'h10, 8'h10, 8'h10, 8'h10);
        stepS(8'h10, 8'h90, 8'h10, 8'h10);
        expTrig(1, 0, cyc);
        stepS(8'h10, 8'h90, 8'h10, 8'h10);
        chk("t6_post", st, S_POST);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_status", st, S_OFF);
        chk("t6_async_trig", tr, 0);
        step(1'b0); step(1'b0);
        chk("t6_in_reset", st, S_OFF);
        rst_n = 1'b1;
        pulseRec();
        chk("t6_via_idle", st, S_OFF);
        step(1'b0);
        pulseRec();
        chk("t6_wait_record_after_reset", st, S_WAIT);
        bus.self_trigger_mode = 1'b0;
        step(1'b0);
        chk("t6_abort", st, S_OFF);

        step(1'b0); step(1'b0);
        chk("trig_queue_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
